// File: rtl/sram_sync.sv
// Synchronous single-port SRAM with handshake requests and an init sweep.
// Define SRAM_PARITY_EN to store and check an even-parity bit per word.
module sram_sync #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDR_WIDTH    = 8,
  parameter int RAM_DEPTH     = 256,
  parameter int PRELOAD_ADDR0 = 50,
  parameter int PRELOAD_VAL0  = 115,
  parameter int PRELOAD_ADDR1 = 242,
  parameter int PRELOAD_VAL1  = 120
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_address,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  input  logic                  clear,
  output logic                  busy,
  output logic                  parity_err
);

`ifdef SRAM_PARITY_EN
  localparam int MW = DATA_WIDTH + 1;
`else
  localparam int MW = DATA_WIDTH;
`endif

  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(RAM_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] PA0 =
    ADDR_WIDTH'(PRELOAD_ADDR0);
  localparam logic [ADDR_WIDTH-1:0] PA1 =
    ADDR_WIDTH'(PRELOAD_ADDR1);
  localparam logic [DATA_WIDTH-1:0] PV0 =
    DATA_WIDTH'(PRELOAD_VAL0);
  localparam logic [DATA_WIDTH-1:0] PV1 =
    DATA_WIDTH'(PRELOAD_VAL1);

  typedef enum logic {INIT, READY} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;

  logic [MW-1:0]         mem [RAM_DEPTH];

  logic                  in_range;
  logic                  accept;
  logic                  rd_acc;
  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [MW-1:0]         wword;
  logic [MW-1:0]         rword;
  logic [DATA_WIDTH-1:0] rsp_data_d;

  assign busy      = (state_q == INIT);
  assign req_ready = (state_q == READY) && !clear;
  assign accept    = req_valid && req_ready;
  assign rd_acc    = accept && !req_write;
  assign in_range  =
    {1'b0, req_address} < (ADDR_WIDTH + 1)'(RAM_DEPTH);

  // The sweep owns the write port for the whole of INIT.
  always_comb begin
    we    = 1'b0;
    waddr = req_address;
    wdata = req_wdata;
    if (state_q == INIT) begin
      we    = 1'b1;
      waddr = cnt_q;
      if (cnt_q == PA0)      wdata = PV0;
      else if (cnt_q == PA1) wdata = PV1;
      else                   wdata = '0;
    end else begin
      we = accept && req_write && in_range;
    end
  end

`ifdef SRAM_PARITY_EN
  assign wword = {^wdata, wdata};
`else
  assign wword = wdata;
`endif

  always_ff @(posedge clk) begin
    if (we && !reset) mem[waddr] <= wword;
  end

  assign rword      = mem[req_address];
  assign rsp_data_d = in_range ? rword[DATA_WIDTH-1:0] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= rd_acc;
      if (rd_acc) rsp_data_q <= rsp_data_d;
      unique case (state_q)
        INIT: begin
          if (cnt_q == LAST) begin
            state_q <= READY;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        READY: begin
          if (clear) begin
            state_q <= INIT;
            cnt_q   <= '0;
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

`ifdef SRAM_PARITY_EN
  logic perr_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) perr_q <= 1'b0;
    else if (rd_acc) perr_q <= in_range && (^rword);
    else perr_q <= 1'b0;
  end
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_sync.sv
// Directed bench for sram_sync: sweep, read/write, clear, reset, range.
module tb_sram_sync;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_write, clear;
  logic [7:0]  req_address;
  logic [15:0] req_wdata;
  logic        req_ready, rsp_valid, busy, parity_err;
  logic [15:0] rsp_data;

  logic        b_valid, b_write;
  logic [7:0]  b_addr;
  logic [15:0] b_wdata;
  logic        b_ready, b_rsp_valid, b_busy, b_perr;
  logic [15:0] b_rsp_data;

  int checks = 0;
  int errors = 0;
  int n;

  always #5 clk = ~clk;

  sram_sync dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_address(req_address),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .clear(clear),
    .busy(busy), .parity_err(parity_err)
  );

  sram_sync #(.RAM_DEPTH(200)) dut_b (
    .clk(clk), .reset(reset),
    .req_valid(b_valid), .req_ready(b_ready),
    .req_write(b_write), .req_address(b_addr),
    .req_wdata(b_wdata), .rsp_valid(b_rsp_valid),
    .rsp_data(b_rsp_data), .clear(1'b0),
    .busy(b_busy), .parity_err(b_perr)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sweep_len(output int cnt);
    cnt = 0;
    while (busy && cnt < 400) begin
      tick();
      cnt++;
    end
  endtask

  task automatic wr(input logic [7:0] a,
                    input logic [15:0] d);
    req_valid = 1'b1; req_write = 1'b1;
    req_address = a; req_wdata = d;
    #1;
    chk("wr_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    chk("wr_no_rsp", rsp_valid, 0);
  endtask

  task automatic rd(input logic [7:0] a,
                    input logic [15:0] e);
    req_valid = 1'b1; req_write = 1'b0;
    req_address = a;
    #1;
    chk("rd_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    chk("rd_valid", rsp_valid, 1);
    chk("rd_data", rsp_data, e);
    chk("rd_perr", parity_err, 0);
    tick();
    chk("rd_pulse", rsp_valid, 0);
    chk("rd_hold", rsp_data, e);
  endtask

  task automatic b_wr(input logic [7:0] a,
                      input logic [15:0] d);
    b_valid = 1'b1; b_write = 1'b1;
    b_addr = a; b_wdata = d;
    #1;
    chk("b_wr_ready", b_ready, 1);
    tick();
    b_valid = 1'b0;
    chk("b_wr_no_rsp", b_rsp_valid, 0);
  endtask

  task automatic b_rd(input logic [7:0] a,
                      input logic [15:0] e);
    b_valid = 1'b1; b_write = 1'b0; b_addr = a;
    tick();
    b_valid = 1'b0;
    chk("b_rd_valid", b_rsp_valid, 1);
    chk("b_rd_data", b_rsp_data, e);
    chk("b_rd_perr", b_perr, 0);
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0;
    req_valid = 1'b0; req_write = 1'b0;
    req_address = '0; req_wdata = '0;
    b_valid = 1'b0; b_write = 1'b0;
    b_addr = '0; b_wdata = '0;
    repeat (3) tick();
    chk("rst_busy", busy, 1);
    chk("rst_ready", req_ready, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_perr", parity_err, 0);
    reset = 1'b0;

    // power-on sweep
    sweep_len(n);
    chk("por_sweep_len", n, 256);
    chk("por_ready", req_ready, 1);
    chk("b_done", b_busy, 0);
    rd(8'd50, 16'd115);
    rd(8'd242, 16'd120);
    rd(8'd0, 16'd0);
    rd(8'd255, 16'd0);

    // write then read
    wr(8'd124, 16'h3779);
    rd(8'd124, 16'h3779);
    rd(8'd123, 16'h0000);
    rd(8'd125, 16'h0000);

    // back-to-back reads
    req_valid = 1'b1; req_write = 1'b0;
    req_address = 8'd50;
    tick();
    chk("b2b_v0", rsp_valid, 1);
    chk("b2b_d0", rsp_data, 115);
    req_address = 8'd124;
    tick();
    chk("b2b_v1", rsp_valid, 1);
    chk("b2b_d1", rsp_data, 16'h3779);
    req_address = 8'd242;
    tick();
    chk("b2b_v2", rsp_valid, 1);
    chk("b2b_d2", rsp_data, 120);
    req_address = 8'd7;
    tick();
    chk("b2b_v3", rsp_valid, 1);
    chk("b2b_d3", rsp_data, 0);
    req_valid = 1'b0;
    tick();
    chk("b2b_end", rsp_valid, 0);

    // clear has priority over a request
    wr(8'd10, 16'hBEEF);
    rd(8'd10, 16'hBEEF);
    clear = 1'b1; req_valid = 1'b1;
    req_write = 1'b0; req_address = 8'd50;
    #1;
    chk("clr_ready", req_ready, 0);
    tick();
    clear = 1'b0; req_valid = 1'b0;
    chk("clr_no_rsp", rsp_valid, 0);
    chk("clr_busy", busy, 1);
    sweep_len(n);
    chk("clr_sweep_len", n, 256);
    rd(8'd10, 16'd0);
    rd(8'd50, 16'd115);

    // reset in the middle of a sweep
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    repeat (100) tick();
    chk("mid_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 1);
    chk("mid_rst_ready", req_ready, 0);
    tick();
    reset = 1'b0;
    clear = 1'b1;
    sweep_len(n);
    clear = 1'b0;
    chk("mid_sweep_len", n, 256);
    rd(8'd242, 16'd120);

    // out-of-range on the 200-word instance
    chk("b_ready_idle", b_busy, 0);
    b_wr(8'd20, 16'h00AA);
    b_rd(8'd20, 16'h00AA);
    b_wr(8'd220, 16'h1234);
    b_rd(8'd220, 16'h0000);
    b_rd(8'd20, 16'h00AA);
    b_rd(8'd199, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
